serv_decode_seq_w: RTL
======================

Name: serv_decode_seq_w

Overview:
- Parametrised successor to the single-bit SERV decoder/sequencer. Processes W bits per cycle (W = 1, 2, 4 or 8), so one pass over a 32-bit operand takes 32/W cycles.
- Latches each fetched instruction, drives the IDLE/INIT/RUN/TRAP sequencer and serialises the immediate W bits per cycle.
- Adds illegal-opcode trapping, which the 1-bit generation lacks.
- Sits between the instruction bus and the ctrl/alu/mem/csr/regfile units.

Parameters:
- W, 1, bits processed per cycle. Legal values 1, 2, 4, 8; any other value is a compile-time error.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_wb_rdt  in  32  fetched instruction
- i_wb_en  in  1  instruction-bus ack; latch i_wb_rdt
- i_mem_dbus_ack  in  1  data-bus ack
- i_mem_misalign  in  1  memory address misaligned
- i_ctrl_misalign  in  1  jump target misaligned
- i_alu_cmp  in  1  branch compare result
- o_ibus_active  out  1  state==IDLE
- o_cnt  out  5  bit index of current lane 0 (multiple of W)
- o_cnt_en  out  1  state!=IDLE
- o_cnt_done  out  1  o_cnt==32-W
- o_init  out  1  state==INIT
- o_trap  out  1  state==TRAP
- o_rf_rd_en  out  1  register write enable
- o_rd_addr, o_rs1_addr, o_rs2_addr  out  5 each  register addresses
- o_funct3  out  3  funct3 field
- o_imm  out  W  immediate bits [o_cnt+W-1:o_cnt]
- o_op_b_imm  out  1  operand B is the immediate
- o_ctrl_jump  out  1  JAL, JALR, or taken branch
- o_mem_en  out  1  memory op active
- o_mem_cmd  out  1  1 = store
- o_mem_dat_valid  out  W  per-lane data valid
- o_csr_mcause  out  4  trap cause

Behaviour:
- Latching:
  - On i_wb_en, register rd/rs1/rs2/funct3/opcode[6:2]/imm from i_wb_rdt.
  - go <= i_wb_en, registered one cycle later; go is cleared by i_rst.
  - Latched fields are not reset.
- Counter:
  - cnt <= cnt + W while o_cnt_en, wrapping 32-W -> 0.
  - Reset: cnt=0, state=IDLE, go=0.
  - Reset values of outputs: o_ibus_active=1; o_cnt_en, o_init, o_trap, o_rf_rd_en, o_mem_en=0.
- State transitions:
  - IDLE, go:
    - unknown opcode (not LOAD/STORE/OPIMM/OP/AUIPC/LUI/BRANCH/JAL/JALR/SYSTEM) or ECALL/EBREAK -> TRAP
    - else branch/slt/JAL/JALR/mem/shift -> INIT
    - else -> RUN
  - IDLE, i_mem_dbus_ack -> RUN. If go and i_mem_dbus_ack are high in the same cycle, the ack wins.
  - INIT, o_cnt_done:
    - i_mem_misalign, or (o_ctrl_jump & i_ctrl_misalign) -> TRAP
    - else mem op -> IDLE (wait for ack)
    - else -> RUN
  - RUN or TRAP, o_cnt_done -> IDLE.
  - A pass therefore lasts exactly 32/W cycles.
- Immediate serialisation:
  - Lane k carries the I/S/B/U/J immediate bit o_cnt+k, using the same bit-selection rules as the 1-bit decoder applied per lane.
  - Sign lanes replicate imm[31]; the J/B bit-0 lane is 0.
- Register write: o_rf_rd_en = RUN & !trap & !STORE & !BRANCH & rd!=0.
- o_mem_dat_valid lane k:
  - byte access: (o_cnt+k)<8
  - half access: (o_cnt+k)<16
  - word access: all ones
- Trap cause priority, high to low:
  - illegal -> 2
  - EBREAK -> 3
  - ECALL -> 11
  - store misalign -> 6
  - load misalign -> 4
  - jump misalign -> 0
- Reset mid-pass returns to IDLE next cycle; no partial write (o_rf_rd_en=0).

Optional Feature:
- Macro: SERV_DECODE_MISALIGN_TRAP_EN.
- Defined: misalignment traps as described in Behaviour.
- Undefined:
  - i_mem_misalign and i_ctrl_misalign are ignored; INIT never transitions to TRAP.
  - Causes 0/4/6 are never produced.
  - Illegal-opcode and ECALL/EBREAK traps remain.

Test Plan:
- W=1, ADDI x5,x0,7 (0x00700293) -> RUN for 32 cycles; o_imm bits 0..2 =1, rest 0; o_rf_rd_en=1; back to IDLE at cycle 33.
- W=4, same instruction -> RUN for 8 cycles; o_imm=4'h7 at o_cnt=0, then 0; o_cnt steps 0,4,...,28.
- W=2, LW with i_mem_misalign=1 after 16 INIT cycles -> TRAP, o_csr_mcause=4; with macro undefined -> IDLE, then RUN on i_mem_dbus_ack.
- W=8, instruction 0xFFFFFFFF (illegal) -> TRAP for 4 cycles, o_csr_mcause=2, o_rf_rd_en=0.
- W=4, LB -> o_mem_dat_valid=4'hF at o_cnt=0,4 and 4'h0 at o_cnt>=8.
- W=1, assert i_rst at RUN cnt=10 -> next cycle state=IDLE, cnt=0, o_ibus_active=1.

Source files
------------

// File: rtl/serv_decode_seq_w.sv
// W-bit-per-cycle SERV decoder/sequencer: latches the instruction, runs IDLE/INIT/RUN/TRAP
// and serialises the immediate. Define SERV_DECODE_MISALIGN_TRAP_EN to enable misalignment traps.
module serv_decode_seq_w #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic [31:0]  i_wb_rdt,
  input  logic         i_wb_en,
  input  logic         i_mem_dbus_ack,
  input  logic         i_mem_misalign,
  input  logic         i_ctrl_misalign,
  input  logic         i_alu_cmp,
  output logic         o_ibus_active,
  output logic [4:0]   o_cnt,
  output logic         o_cnt_en,
  output logic         o_cnt_done,
  output logic         o_init,
  output logic         o_trap,
  output logic         o_rf_rd_en,
  output logic [4:0]   o_rd_addr,
  output logic [4:0]   o_rs1_addr,
  output logic [4:0]   o_rs2_addr,
  output logic [2:0]   o_funct3,
  output logic [W-1:0] o_imm,
  output logic         o_op_b_imm,
  output logic         o_ctrl_jump,
  output logic         o_mem_en,
  output logic         o_mem_cmd,
  output logic [W-1:0] o_mem_dat_valid,
  output logic [3:0]   o_csr_mcause
);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("serv_decode_seq_w: W must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] CNT_STEP  = 5'(W);
  localparam logic [4:0] CNT_LAST  = 5'(32 - W);
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    TRAP = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic        go_r;
  logic [4:0]  opcode_r;
  logic [4:0]  rd_r, rs1_r, rs2_r;
  logic [2:0]  funct3_r;
  logic [31:0] imm_r;
  logic [3:0]  mcause_r;

  // Full 32-bit immediate for the instruction format implied by the opcode
  function automatic logic [31:0] decode_imm(input logic [4:0] op, input logic [31:7] ins);
    logic [31:0] imm;
    case (op)
      OP_STORE:         imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      OP_BRANCH:        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_AUIPC, OP_LUI: imm = {ins[31:12], 12'h000};
      OP_JAL:           imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default:          imm = {{21{ins[31]}}, ins[30:20]};
    endcase
    return imm;
  endfunction

  logic is_load_s, is_store_s, is_mem_s, is_op_s, is_opimm_s, is_branch_s;
  logic is_jal_s, is_jalr_s, is_system_s, legal_s, ecall_ebreak_s, ebreak_s;
  logic slt_s, shift_s, need_init_s, ctrl_jump_s, mem_mis_s, jmp_mis_s, cnt_done_s;
  logic unused_s;
  logic [3:0] cause_s;
  logic [W-1:0] dat_valid_s;

  assign is_load_s   = (opcode_r == OP_LOAD);
  assign is_store_s  = (opcode_r == OP_STORE);
  assign is_mem_s    = is_load_s | is_store_s;
  assign is_op_s     = (opcode_r == OP_OP);
  assign is_opimm_s  = (opcode_r == OP_OPIMM);
  assign is_branch_s = (opcode_r == OP_BRANCH);
  assign is_jal_s    = (opcode_r == OP_JAL);
  assign is_jalr_s   = (opcode_r == OP_JALR);
  assign is_system_s = (opcode_r == OP_SYSTEM);
  assign legal_s     = is_mem_s | is_op_s | is_opimm_s | is_branch_s | is_jal_s | is_jalr_s |
                       is_system_s | (opcode_r == OP_AUIPC) | (opcode_r == OP_LUI);
  // ECALL/EBREAK share funct3=0; instruction bit 20 (imm bit 0) tells them apart
  assign ecall_ebreak_s = is_system_s & (funct3_r == 3'b000);
  assign ebreak_s       = ecall_ebreak_s & imm_r[0];
  assign slt_s       = (is_op_s | is_opimm_s) & (funct3_r[2:1] == 2'b01);
  assign shift_s     = (is_op_s | is_opimm_s) & (funct3_r[1:0] == 2'b01);
  assign need_init_s = is_branch_s | slt_s | is_jal_s | is_jalr_s | is_mem_s | shift_s;
  assign ctrl_jump_s = is_jal_s | is_jalr_s | (is_branch_s & i_alu_cmp);
  assign cnt_done_s  = (cnt_r == CNT_LAST);

`ifdef SERV_DECODE_MISALIGN_TRAP_EN
  assign mem_mis_s = is_mem_s & i_mem_misalign;
  assign jmp_mis_s = ctrl_jump_s & i_ctrl_misalign;
  assign unused_s  = &{1'b0, i_wb_rdt[1:0]};
`else
  assign mem_mis_s = 1'b0;
  assign jmp_mis_s = 1'b0;
  assign unused_s  = &{1'b0, i_wb_rdt[1:0], i_mem_misalign, i_ctrl_misalign};
`endif

  // Trap cause in priority order
  always_comb begin
    cause_s = 4'd0;
    if (!legal_s)                      cause_s = 4'd2;
    else if (ebreak_s)                 cause_s = 4'd3;
    else if (ecall_ebreak_s)           cause_s = 4'd11;
    else if (mem_mis_s & is_store_s)   cause_s = 4'd6;
    else if (mem_mis_s & is_load_s)    cause_s = 4'd4;
    else                               cause_s = 4'd0;
  end

  // Per-lane data valid by access size
  always_comb begin
    dat_valid_s = '0;
    for (int k = 0; k < int'(W); k++) begin
      case (funct3_r[1:0])
        2'b00:   dat_valid_s[k] = (({1'b0, cnt_r} + 6'(k)) < 6'd8);
        2'b01:   dat_valid_s[k] = (({1'b0, cnt_r} + 6'(k)) < 6'd16);
        default: dat_valid_s[k] = 1'b1;
      endcase
    end
  end

  // Instruction field latch; deliberately not reset
  always_ff @(posedge clk) begin
    if (i_wb_en) begin
      opcode_r <= i_wb_rdt[6:2];
      rd_r     <= i_wb_rdt[11:7];
      funct3_r <= i_wb_rdt[14:12];
      rs1_r    <= i_wb_rdt[19:15];
      rs2_r    <= i_wb_rdt[24:20];
      imm_r    <= decode_imm(i_wb_rdt[6:2], i_wb_rdt[31:7]);
    end
  end

  // Sequencer: state, bit counter, go strobe and trap cause
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      cnt_r    <= 5'd0;
      go_r     <= 1'b0;
      mcause_r <= 4'd0;
    end else begin
      go_r <= i_wb_en;
      if (state_r != IDLE) cnt_r <= cnt_r + CNT_STEP;
      case (state_r)
        IDLE: begin
          if (i_mem_dbus_ack) begin
            state_r <= RUN;
          end else if (go_r) begin
            if (!legal_s || ecall_ebreak_s) begin
              state_r  <= TRAP;
              mcause_r <= cause_s;
            end else if (need_init_s) begin
              state_r <= INIT;
            end else begin
              state_r <= RUN;
            end
          end
        end
        INIT: begin
          if (cnt_done_s) begin
            if (mem_mis_s || jmp_mis_s) begin
              state_r  <= TRAP;
              mcause_r <= cause_s;
            end else if (is_mem_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN, TRAP: if (cnt_done_s) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign o_ibus_active   = (state_r == IDLE);
  assign o_cnt_en        = (state_r != IDLE);
  assign o_init          = (state_r == INIT);
  assign o_trap          = (state_r == TRAP);
  assign o_cnt           = cnt_r;
  assign o_cnt_done      = cnt_done_s;
  assign o_rf_rd_en      = (state_r == RUN) & !is_store_s & !is_branch_s & (rd_r != 5'd0);
  assign o_rd_addr       = rd_r;
  assign o_rs1_addr      = rs1_r;
  assign o_rs2_addr      = rs2_r;
  assign o_funct3        = funct3_r;
  assign o_imm           = W'(imm_r >> cnt_r);
  assign o_op_b_imm      = !(is_op_s | is_branch_s);
  assign o_ctrl_jump     = ctrl_jump_s;
  assign o_mem_en        = is_mem_s & ((state_r == INIT) | (state_r == RUN));
  assign o_mem_cmd       = is_store_s;
  assign o_mem_dat_valid = dat_valid_s;
  assign o_csr_mcause    = mcause_r;

endmodule
